// File: rtl/accum_array_multi.sv
// accum_array_multi: DEPTH-entry {key, count} table for the word-count pipeline.
// Each write either adds its count to the stored count (accumulate) or replaces
// the entry (overwrite). A 3-stage write pipeline (sample / read old / commit)
// forwards the committing result to a same-address write one cycle behind, so
// back-to-back runs total exactly. A clear FSM drains in-flight writes, then
// sweeps zeros over every address.
// Build option: define ACCUM_SATURATE_EN to clamp accumulated counts at
// 2**CNT_W-1 instead of wrapping; in both builds a carry sets the sticky
// overflow flag, which is cleared by reset or an accepted clear_kick.
module accum_array_multi #(
    parameter int KEY_W  = 32,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_kick,
    output logic                     clear_busy,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [KEY_W+CNT_W-1:0]   din,
    input  logic                     we,
    input  logic                     wr_mode,
    output logic [KEY_W+CNT_W-1:0]   q,
    output logic                     collision,
    output logic                     overflow
);

    localparam int DATA_W = KEY_W + CNT_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    // Table storage (not reset; a clear sweep initialises it)
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write pipeline registers
    logic              r_s0_valid;
    logic [ADDR_W-1:0] r_s0_addr;
    logic [DATA_W-1:0] r_s0_din;
    logic              r_s0_mode;
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [DATA_W-1:0] r_s1_din;
    logic              r_s1_mode;
    logic [DATA_W-1:0] r_s1_old;

    // Read port and flags
    logic [DATA_W-1:0] r_q;
    logic              r_overflow;

    // Clear FSM
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_drain_cnt;
    logic              w_drain_nxt;
    logic [ADDR_W-1:0] r_sweep_addr;
    logic [ADDR_W-1:0] w_sweep_nxt;
    logic              w_sweep_we;
    logic              w_kick_acc;
    logic              w_busy;

    // Commit-stage datapath
    logic [KEY_W-1:0]  w_old_key;
    logic [CNT_W-1:0]  w_old_cnt;
    logic [KEY_W-1:0]  w_din_key;
    logic [CNT_W-1:0]  w_din_cnt;
    logic [CNT_W:0]    w_sum;
    logic              w_carry;
    logic [CNT_W-1:0]  w_acc_cnt;
    logic [DATA_W-1:0] w_s2_result;
    logic              w_s2_acc;
    logic              w_fwd;

    assign w_busy     = (r_state != ST_IDLE);
    assign clear_busy = w_busy;
    assign q          = r_q;
    assign overflow   = r_overflow;

    assign w_old_key  = r_s1_old[DATA_W-1:CNT_W];
    assign w_old_cnt  = r_s1_old[CNT_W-1:0];
    assign w_din_key  = r_s1_din[DATA_W-1:CNT_W];
    assign w_din_cnt  = r_s1_din[CNT_W-1:0];
    assign w_sum      = {1'b0, w_old_cnt} + {1'b0, w_din_cnt};
    assign w_carry    = w_sum[CNT_W];
    assign w_s2_acc   = r_s1_valid & ~r_s1_mode;

`ifdef ACCUM_SATURATE_EN
    assign w_acc_cnt  = w_carry ? '1 : w_sum[CNT_W-1:0];
`else
    assign w_acc_cnt  = w_sum[CNT_W-1:0];
`endif

    assign w_s2_result = r_s1_mode ? r_s1_din : {w_din_key, w_acc_cnt};
    assign collision   = w_s2_acc & (w_old_cnt != '0) & (w_old_key != w_din_key);

    // The committing entry is not yet visible in RAM when the next write reads it
    assign w_fwd = r_s1_valid & r_s0_valid & (r_s1_addr == r_s0_addr);

    // S0: sample write requests; writes are dropped while the clear runs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0_valid <= 1'b0;
            r_s0_addr  <= '0;
            r_s0_din   <= '0;
            r_s0_mode  <= 1'b0;
        end else begin
            r_s0_valid <= we & ~w_busy;
            r_s0_addr  <= addr;
            r_s0_din   <= din;
            r_s0_mode  <= wr_mode;
        end
    end

    // S1: fetch the old entry, taking the commit-stage result on an address match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_din   <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_old   <= '0;
        end else begin
            r_s1_valid <= r_s0_valid;
            r_s1_addr  <= r_s0_addr;
            r_s1_din   <= r_s0_din;
            r_s1_mode  <= r_s0_mode;
            r_s1_old   <= w_fwd ? w_s2_result : r_mem[r_s0_addr];
        end
    end

    // RAM write port: sweep zeros take priority over pipeline commits
    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_mem[r_sweep_addr] <= '0;
        end else if (r_s1_valid) begin
            r_mem[r_s1_addr] <= w_s2_result;
        end
    end

    // Read port: committed contents only, updated on non-write cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (!we) begin
            r_q <= r_mem[addr];
        end
    end

    // Sticky overflow: an accepted clear drops it, a same-cycle carry re-sets it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= (r_overflow & ~w_kick_acc) | (w_s2_acc & w_carry);
        end
    end

    // Clear FSM state and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_drain_cnt  <= 1'b0;
            r_sweep_addr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_drain_cnt  <= w_drain_nxt;
            r_sweep_addr <= w_sweep_nxt;
        end
    end

    // Clear FSM next state: two drain cycles, then one zero write per address
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_sweep_nxt = r_sweep_addr;
        w_sweep_we  = 1'b0;
        w_kick_acc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_kick) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = 1'b0;
                    w_kick_acc  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt) begin
                    w_state_nxt = ST_SWEEP;
                    w_sweep_nxt = '0;
                end else begin
                    w_drain_nxt = 1'b1;
                end
            end
            ST_SWEEP: begin
                w_sweep_we = 1'b1;
                if (r_sweep_addr == LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_sweep_nxt = r_sweep_addr + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_accum_array_multi.sv
// Self-checking bench for accum_array_multi. The reference model applies each
// accepted write to a plain array in issue order, tracks the clear window as a
// cycle countdown, and predicts collision/overflow from the table rules.
// Honors ACCUM_SATURATE_EN the same way the design does.
module tb_accum_array_multi;

    localparam int KEY_W  = 32;
    localparam int CNT_W  = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int DW     = KEY_W + CNT_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear_kick;
    logic              clear_busy;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     din;
    logic              we;
    logic              wr_mode;
    logic [DW-1:0]     q;
    logic              collision;
    logic              overflow;

    accum_array_multi #(
        .KEY_W (KEY_W),
        .CNT_W (CNT_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear_kick(clear_kick),
        .clear_busy(clear_busy),
        .addr      (addr),
        .din       (din),
        .we        (we),
        .wr_mode   (wr_mode),
        .q         (q),
        .collision (collision),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    int unsigned m_left   = 0;
    bit          c_cur    = 1'b0;
    bit          c_prev   = 1'b0;
    int          coll_seen = 0;
    bit          m_ovf    = 1'b0;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] snap  [DEPTH];
    logic [31:0]   keys  [3] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F};
    logic [31:0]   dir_keys [4] = '{32'hDEAD_BEEF, 32'hABAD_CAFE, 32'hFEFE_FEFE, 32'h3434_3434};
    int unsigned   seq_a [13] = '{0, 0, 0, 1, 1, 0, 0, 2, 3, 0, 0, 1, 3};

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Table rules: accumulate adds counts (wrap or clamp), overwrite replaces
    function automatic bit model_write(input int unsigned a, input logic [DW-1:0] d, input bit m);
        logic [31:0] ok, oc, dk, dc;
        longint unsigned s;
        bit c;
        c = 1'b0;
        if (m) begin
            m_mem[a] = d;
        end else begin
            {ok, oc} = m_mem[a];
            {dk, dc} = d;
            c = (oc != 0) && (ok != dk);
            s = 64'(oc) + 64'(dc);
            if (s > 64'hFFFF_FFFF) begin
                m_ovf = 1'b1;
`ifdef ACCUM_SATURATE_EN
                s = 64'hFFFF_FFFF;
`else
                s = s - 64'h1_0000_0000;
`endif
            end
            m_mem[a] = {dk, s[31:0]};
        end
        return c;
    endfunction

    task automatic tick();
        bit acc_w, acc_k, coll;
        acc_w = we && (m_left == 0);
        acc_k = clear_kick && (m_left == 0);
        coll  = 1'b0;
        if (acc_w) coll = model_write(int'(addr), din, wr_mode);
        if (acc_k) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        if (m_left > 0) m_left--;
        if (acc_k) m_left = DEPTH + 2;
        c_prev = c_cur;
        c_cur  = coll;
        check("busy", DW'(clear_busy), DW'(m_left > 0));
        check("collision", DW'(collision), DW'(c_prev));
        if (collision) coll_seen++;
    endtask

    task automatic wr(input int unsigned a, input logic [DW-1:0] d, input bit m);
        we = 1'b1; addr = ADDR_W'(a); din = d; wr_mode = m;
        tick();
        we = 1'b0;
    endtask

    task automatic flush();
        we = 1'b0;
        repeat (2) tick();
    endtask

    task automatic rd(input int unsigned a, input string tag);
        we = 1'b0; addr = ADDR_W'(a);
        tick();
        check(tag, q, m_mem[a]);
    endtask

    task automatic rd_const(input int unsigned a, input logic [DW-1:0] exp, input string tag);
        we = 1'b0; addr = ADDR_W'(a);
        tick();
        check(tag, q, exp);
    endtask

    task automatic run_clear();
        int nb;
        nb = 0;
        clear_kick = 1'b1;
        tick();
        clear_kick = 1'b0;
        if (clear_busy) nb++;
        for (int i = 0; i < DEPTH + 8; i++) begin
            tick();
            if (clear_busy) nb++;
            else break;
        end
        while (m_left > 0) tick();
        check("clear_len", DW'(nb), DW'(DEPTH + 2));
    endtask

    task automatic read_all(input string tag);
        flush();
        for (int a = 0; a < DEPTH; a++) rd(a, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; clear_kick = 1'b0; we = 1'b0; wr_mode = 1'b0;
        addr = '0; din = '0;
        #12;
        check("rst_q", q, '0);
        check("rst_busy", DW'(clear_busy), '0);
        check("rst_coll", DW'(collision), '0);
        check("rst_ovf", DW'(overflow), '0);
        reset = 1'b0;

        // Power-up clear and full read-back
        run_clear();
        read_all("init_zero");

        // Interleaved back-to-back accumulate runs
        foreach (seq_a[i]) wr(seq_a[i], {dir_keys[seq_a[i]], 32'd1}, 1'b0);
        flush();
        rd_const(0, {32'hDEAD_BEEF, 32'd7}, "b2b_a0");
        rd_const(1, {32'hABAD_CAFE, 32'd3}, "b2b_a1");
        rd_const(2, {32'hFEFE_FEFE, 32'd1}, "b2b_a2");
        rd_const(3, {32'h3434_3434, 32'd2}, "b2b_a3");

        // Key collision, then overwrite
        coll_seen = 0;
        wr(5, {32'h1111_1111, 32'd4}, 1'b0);
        wr(5, {32'h2222_2222, 32'd1}, 1'b0);
        flush();
        check("coll_pulses", DW'(coll_seen), DW'(1));
        rd_const(5, {32'h2222_2222, 32'd5}, "coll_entry");
        coll_seen = 0;
        wr(5, {32'h3333_3333, 32'd9}, 1'b1);
        flush();
        check("ovw_no_coll", DW'(coll_seen), DW'(0));
        rd_const(5, {32'h3333_3333, 32'd9}, "ovw_entry");
        check("ovf_pre", DW'(overflow), DW'(0));

        // Count overflow at one address
        wr(20, {32'hA5A5_A5A5, 32'hFFFF_FFFF}, 1'b0);
        wr(20, {32'hA5A5_A5A5, 32'd2}, 1'b0);
        flush();
`ifdef ACCUM_SATURATE_EN
        rd_const(20, {32'hA5A5_A5A5, 32'hFFFF_FFFF}, "ovf_entry");
`else
        rd_const(20, {32'hA5A5_A5A5, 32'd1}, "ovf_entry");
`endif
        check("ovf_flag", DW'(overflow), DW'(1));

        // Randomised bursts against the model
        for (int b = 0; b < 40; b++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                logic [31:0] cnt;
                cnt = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 20));
                wr($urandom_range(0, 15), {keys[$urandom_range(0, 2)], cnt}, ($urandom_range(0, 3) == 0));
            end
            flush();
            for (int j = 0; j < 4; j++) rd($urandom_range(0, 15), "rand_rd");
            check("rand_ovf", DW'(overflow), DW'(m_ovf));
        end

        // Clear with writes in flight; writes and kicks during the sweep are ignored
        wr(40, {32'h4040_4040, 32'd1}, 1'b0);
        wr(41, {32'h4141_4141, 32'd1}, 1'b0);
        we = 1'b1; addr = 8'd42; din = {32'h4242_4242, 32'd1}; wr_mode = 1'b0;
        clear_kick = 1'b1;
        tick();
        clear_kick = 1'b0;
        for (int i = 0; i < DEPTH + 8 && m_left > 0; i++) begin
            we = 1'b1;
            addr = ADDR_W'($urandom);
            din = {32'($urandom), 32'($urandom)};
            wr_mode = 1'($urandom);
            clear_kick = 1'($urandom);
            tick();
        end
        we = 1'b0; clear_kick = 1'b0; wr_mode = 1'b0;
        check("inflight_done", DW'(m_left), DW'(0));
        read_all("inflight_zero");
        check("inflight_ovf", DW'(overflow), DW'(m_ovf));

        // Reset while the sweep is at address 100
        wr(200, {32'hC8C8_C8C8, 32'd7}, 1'b0);
        flush();
        snap = m_mem;
        clear_kick = 1'b1;
        tick();
        clear_kick = 1'b0;
        repeat (102) tick();
        reset = 1'b1;
        #1;
        check("midrst_busy", DW'(clear_busy), '0);
        check("midrst_q", q, '0);
        check("midrst_ovf", DW'(overflow), '0);
        #10;
        reset = 1'b0;
        m_left = 0; c_cur = 1'b0; c_prev = 1'b0; m_ovf = 1'b0;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = (a < 100) ? '0 : snap[a];
        flush();
        rd(99, "partial_lo");
        rd(100, "partial_edge");
        rd(200, "partial_hi");
        run_clear();
        read_all("reclear_zero");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
